cmd_reader: RTL and testbench

- Receive side of the UART command console; the counterpart of the string printer.
- Collects bytes from the UART receiver into a line buffer and folds letters to lowercase.
- On a line terminator, matches the buffered line against a fixed command table.
- Presents the result as a command id, held until the control FSM acknowledges it.

---
 rtl/cmd_reader_if.sv | 21 ++
 rtl/cmd_reader.sv | 201 ++++++++++++++++++++
 tb/tb_cmd_reader.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_reader_if.sv
// Handshake bundle between the UART receiver / control FSM and the command reader.
// The master side drives received bytes and acknowledges; the slave side reports results.
interface cmd_reader_if;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       cmd_ack;
    logic       cmd_valid;
    logic       cmd_err;
    logic [1:0] cmd_id;
    logic [1:0] reader_state;

    modport master (
        output rx_data, rx_done, cmd_ack,
        input  cmd_valid, cmd_err, cmd_id, reader_state
    );

    modport slave (
        input  rx_data, rx_done, cmd_ack,
        output cmd_valid, cmd_err, cmd_id, reader_state
    );
endinterface

// File: rtl/cmd_reader.sv
// Console command reader: buffers a line with letter folding, matches it against
// a fixed four-entry command table and holds the result until acknowledged.
module cmd_reader #(
    parameter int MAX_LEN = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    cmd_reader_if.slave  bus
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int IW = $clog2(MAX_LEN);

    localparam logic [1:0] ST_RECEIVE = 2'd0;
    localparam logic [1:0] ST_DROP    = 2'd1;
    localparam logic [1:0] ST_MATCH   = 2'd2;
    localparam logic [1:0] ST_REPORT  = 2'd3;

    localparam logic [LW-1:0] LEN_FULL = LW'(MAX_LEN);

    logic [1:0]    state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] idx_q, idx_d;
    logic [1:0]    cand_q, cand_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic          cmd_err_q, cmd_err_d;
    logic [1:0]    cmd_id_q, cmd_id_d;

    logic [7:0]    line_buf_q [MAX_LEN];
    logic          wr_en_s;
    logic [7:0]    wr_byte_s;

    logic          is_term_s;
    logic          is_bs_s;
    logic          is_upper_s;
    logic [7:0]    cur_char_s;
    logic          len_eq_s;
    logic          char_eq_s;
    logic          last_s;

    // Length of each table entry.
    function automatic logic [LW-1:0] table_len(input logic [1:0] c);
        logic [LW-1:0] l;
        case (c)
            2'd0:    l = LW'(3'd4);
            2'd1:    l = LW'(3'd6);
            2'd2:    l = LW'(3'd7);
            2'd3:    l = LW'(3'd5);
            default: l = LW'(3'd0);
        endcase
        return l;
    endfunction

    // Character i of table entry c, left-aligned in a 7-byte row.
    function automatic logic [7:0] table_char(input logic [1:0] c, input logic [2:0] i);
        logic [55:0] row;
        logic [7:0]  ch;
        case (c)
            2'd0:    row = {"help", 24'h000000};
            2'd1:    row = {"led on", 8'h00};
            2'd2:    row = "led off";
            2'd3:    row = {"reset", 16'h0000};
            default: row = 56'h0;
        endcase
        case (i)
            3'd0:    ch = row[55:48];
            3'd1:    ch = row[47:40];
            3'd2:    ch = row[39:32];
            3'd3:    ch = row[31:24];
            3'd4:    ch = row[23:16];
            3'd5:    ch = row[15:8];
            3'd6:    ch = row[7:0];
            default: ch = 8'h00;
        endcase
        return ch;
    endfunction

    assign is_term_s  = (bus.rx_data == 8'h0D) || (bus.rx_data == 8'h0A);
    assign is_bs_s    = (bus.rx_data == 8'h08) || (bus.rx_data == 8'h7F);
    assign is_upper_s = (bus.rx_data >= 8'h41) && (bus.rx_data <= 8'h5A);
    assign cur_char_s = line_buf_q[idx_q[IW-1:0]];
    assign len_eq_s   = (table_len(cand_q) == len_q);
    assign char_eq_s  = (cur_char_s == table_char(cand_q, idx_q[2:0]));
    assign last_s     = (idx_q == (len_q - LW'(1'b1)));

    // Next-state, buffer write and result computation.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        cand_d      = cand_q;
        cmd_valid_d = cmd_valid_q;
        cmd_err_d   = cmd_err_q;
        cmd_id_d    = cmd_id_q;
        wr_en_s     = 1'b0;
        wr_byte_s   = is_upper_s ? (bus.rx_data + 8'h20) : bus.rx_data;

        case (state_q)
            ST_RECEIVE: begin
                if (!bus.rx_done) begin
                    state_d = ST_RECEIVE;
                end else if (is_term_s) begin
                    // An empty line is ignored so CRLF produces a single result.
                    if (len_q != {LW{1'b0}}) begin
                        state_d = ST_MATCH;
                        cand_d  = 2'd0;
                        idx_d   = {LW{1'b0}};
                    end else begin
                        state_d = ST_RECEIVE;
                    end
                end else if (is_bs_s) begin
                    if (len_q != {LW{1'b0}}) begin
                        len_d = len_q - LW'(1'b1);
                    end else begin
                        len_d = len_q;
                    end
                end else if (len_q == LEN_FULL) begin
                    state_d = ST_DROP;
                end else begin
                    wr_en_s = 1'b1;
                    len_d   = len_q + LW'(1'b1);
                end
            end
            ST_DROP: begin
                if (bus.rx_done && is_term_s) begin
                    state_d     = ST_REPORT;
                    cmd_valid_d = 1'b1;
                    cmd_err_d   = 1'b1;
                    cmd_id_d    = 2'd0;
                end else begin
                    state_d = ST_DROP;
                end
            end
            ST_MATCH: begin
                if (len_eq_s && char_eq_s && last_s) begin
                    state_d     = ST_REPORT;
                    cmd_valid_d = 1'b1;
                    cmd_err_d   = 1'b0;
                    cmd_id_d    = cand_q;
                end else if (len_eq_s && char_eq_s) begin
                    idx_d = idx_q + LW'(1'b1);
                end else if (cand_q == 2'd3) begin
                    state_d     = ST_REPORT;
                    cmd_valid_d = 1'b1;
                    cmd_err_d   = 1'b1;
                    cmd_id_d    = 2'd0;
                end else begin
                    cand_d = cand_q + 2'd1;
                    idx_d  = {LW{1'b0}};
                end
            end
            ST_REPORT: begin
                // A byte arriving on the ack edge is lost along with the rest.
                if (bus.cmd_ack) begin
                    state_d     = ST_RECEIVE;
                    cmd_valid_d = 1'b0;
                    cmd_err_d   = 1'b0;
                    cmd_id_d    = 2'd0;
                    len_d       = {LW{1'b0}};
                end else begin
                    state_d = ST_REPORT;
                end
            end
            default: begin
                state_d = ST_RECEIVE;
            end
        endcase
    end

    // Control and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RECEIVE;
            len_q       <= {LW{1'b0}};
            idx_q       <= {LW{1'b0}};
            cand_q      <= 2'd0;
            cmd_valid_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            cmd_id_q    <= 2'd0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            cand_q      <= cand_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_err_q   <= cmd_err_d;
            cmd_id_q    <= cmd_id_d;
        end
    end

    // Line buffer storage; contents are meaningless beyond len_q.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            line_buf_q[len_q[IW-1:0]] <= wr_byte_s;
        end
    end

    assign bus.cmd_valid    = cmd_valid_q;
    assign bus.cmd_err      = cmd_err_q;
    assign bus.cmd_id       = cmd_id_q;
    assign bus.reader_state = state_q;
endmodule

// File: tb/tb_cmd_reader.sv
// Self-checking bench for cmd_reader: table of command lines plus hand-written
// sequences for CRLF, overflow, reset during matching and bytes during a report.
module tb_cmd_reader;
    logic clk;
    logic rst_n;
    cmd_reader_if bus ();

    cmd_reader #(.MAX_LEN(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       err;
        logic [1:0] id;
    } res_t;

    typedef struct packed {
        logic [63:0] txt;
        logic [7:0]  len;
        logic [7:0]  term;
        logic        err;
        logic [1:0]  id;
    } vec_t;

    res_t exp_q[$];
    vec_t vecs[8];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data = b;
        bus.rx_done = 1'b1;
        @(negedge clk);
        bus.rx_done = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic send_packed(input logic [63:0] txt, input int len);
        for (int i = 0; i < len; i++) send_byte(txt[(len - 1 - i) * 8 +: 8]);
    endtask

    // Waits (bounded) for a result and compares it with the oldest expectation.
    task automatic wait_result(input string name);
        int   n = 0;
        res_t e;
        while (!bus.cmd_valid && n < 12) begin
            @(negedge clk);
            n++;
        end
        check({name, " valid"}, int'(bus.cmd_valid), 1);
        if (exp_q.size() == 0) begin
            check({name, " unexpected result"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            if (bus.cmd_valid) begin
                check({name, " err"}, int'(bus.cmd_err), int'(e.err));
                check({name, " id"}, int'(bus.cmd_id), int'(e.id));
            end
        end
    endtask

    task automatic do_ack(input string name);
        @(negedge clk);
        bus.cmd_ack = 1'b1;
        @(negedge clk);
        bus.cmd_ack = 1'b0;
        check({name, " ack valid"}, int'(bus.cmd_valid), 0);
        check({name, " ack state"}, int'(bus.reader_state), 0);
    endtask

    task automatic check_idle(input string name, input int cycles);
        int seen = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (bus.cmd_valid) seen++;
        end
        check({name, " idle"}, seen, 0);
    endtask

    initial begin
        int good;
        rst_n       = 1'b0;
        bus.rx_data = 8'h00;
        bus.rx_done = 1'b0;
        bus.cmd_ack = 1'b0;

        vecs[0] = '{txt: 64'("help"),    len: 8'd4, term: 8'h0D, err: 1'b0, id: 2'd0};
        vecs[1] = '{txt: 64'("led on"),  len: 8'd6, term: 8'h0A, err: 1'b0, id: 2'd1};
        vecs[2] = '{txt: 64'("RESET"),   len: 8'd5, term: 8'h0D, err: 1'b0, id: 2'd3};
        vecs[3] = '{txt: 64'("helq"),    len: 8'd4, term: 8'h0D, err: 1'b1, id: 2'd0};
        vecs[4] = '{txt: 64'("led on "), len: 8'd7, term: 8'h0D, err: 1'b1, id: 2'd0};
        vecs[5] = '{txt: 64'("hel"),     len: 8'd3, term: 8'h0A, err: 1'b1, id: 2'd0};
        vecs[6] = '{txt: 64'("HeLp"),    len: 8'd4, term: 8'h0D, err: 1'b0, id: 2'd0};
        vecs[7] = '{txt: 64'("led ofF"), len: 8'd7, term: 8'h0A, err: 1'b0, id: 2'd2};

        #1;
        check("reset valid", int'(bus.cmd_valid), 0);
        check("reset err", int'(bus.cmd_err), 0);
        check("reset id", int'(bus.cmd_id), 0);
        check("reset state", int'(bus.reader_state), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Result held while unacknowledged.
        exp_q.push_back('{err: 1'b0, id: 2'd0});
        send_str("help");
        send_byte(8'h0D);
        wait_result("help");
        check("report state", int'(bus.reader_state), 3);
        good = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.cmd_valid && !bus.cmd_err && bus.cmd_id == 2'd0) good++;
        end
        check("hold 20", good, 20);
        do_ack("help");

        // CRLF yields a single result.
        exp_q.push_back('{err: 1'b0, id: 2'd2});
        send_str("LED Off");
        send_byte(8'h0D);
        send_byte(8'h0A);
        wait_result("crlf");
        do_ack("crlf");
        check_idle("crlf", 20);

        // Backspace removes the stray character.
        exp_q.push_back('{err: 1'b0, id: 2'd1});
        send_str("led onx");
        send_byte(8'h08);
        send_byte(8'h0A);
        wait_result("bs");
        do_ack("bs");

        // Backspace at empty line has no effect.
        send_byte(8'h08);
        check_idle("bs empty", 3);
        exp_q.push_back('{err: 1'b0, id: 2'd3});
        send_str("reset");
        send_byte(8'h0D);
        wait_result("bs empty reset");
        do_ack("bs empty reset");

        // Overflow drops the line and reports one error.
        repeat (17) send_byte(8'h61);
        check("drop state", int'(bus.reader_state), 1);
        send_byte(8'h08);
        check("drop after bs", int'(bus.reader_state), 1);
        exp_q.push_back('{err: 1'b1, id: 2'd0});
        send_byte(8'h0D);
        wait_result("overflow");
        do_ack("overflow");
        exp_q.push_back('{err: 1'b0, id: 2'd0});
        send_str("help");
        send_byte(8'h0D);
        wait_result("post overflow");
        do_ack("post overflow");

        // Table-driven vectors.
        for (int v = 0; v < 8; v++) begin
            exp_q.push_back('{err: vecs[v].err, id: vecs[v].id});
            send_packed(vecs[v].txt, int'(vecs[v].len));
            send_byte(vecs[v].term);
            wait_result($sformatf("vec%0d", v));
            do_ack($sformatf("vec%0d", v));
        end

        // Reset while matching aborts without a result.
        send_str("reset");
        send_byte(8'h0D);
        check("in match", int'(bus.reader_state), 2);
        rst_n = 1'b0;
        #1;
        check("mid reset valid", int'(bus.cmd_valid), 0);
        check("mid reset state", int'(bus.reader_state), 0);
        @(negedge clk);
        rst_n = 1'b1;
        check_idle("after mid reset", 20);

        // Bytes during a report are dropped.
        exp_q.push_back('{err: 1'b0, id: 2'd0});
        send_str("help");
        send_byte(8'h0D);
        wait_result("report drop");
        send_byte(8'h78);
        do_ack("report drop");
        exp_q.push_back('{err: 1'b1, id: 2'd0});
        send_str("ver");
        send_byte(8'h0D);
        wait_result("ver");
        do_ack("ver");

        // Byte on the same edge as ack is dropped.
        exp_q.push_back('{err: 1'b0, id: 2'd0});
        send_str("help");
        send_byte(8'h0D);
        wait_result("pre same edge");
        @(negedge clk);
        bus.rx_data = 8'h71;
        bus.rx_done = 1'b1;
        bus.cmd_ack = 1'b1;
        @(negedge clk);
        bus.rx_done = 1'b0;
        bus.cmd_ack = 1'b0;
        check("same edge valid", int'(bus.cmd_valid), 0);
        exp_q.push_back('{err: 1'b0, id: 2'd0});
        send_str("help");
        send_byte(8'h0D);
        wait_result("after same edge");
        do_ack("after same edge");

        check("scoreboard empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
